bus_dispatch4_16: RTL and testbench

16-bit one-to-four buffered dispatcher: accepts a word plus a 2-bit destination select on a single valid/ready input port and routes it to one of four independent output lanes, each with its own 2-entry FIFO and valid/ready handshake. It is the distribution counterpart to the datapath's 4:1 16-bit select. It sits between the multicycle CPU datapath (producer) and up to four consumers (write-back targets, I/O registers) that may stall independently.

---
 rtl/bus_dispatch4_16_pkg.sv | 19 +
 rtl/bus_dispatch4_16_if.sv | 30 +++
 rtl/bus_dispatch4_16_lane_fifo2.sv | 70 +++++++
 rtl/bus_dispatch4_16.sv | 51 +++++
 tb/tb_bus_dispatch4_16.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/bus_dispatch4_16_pkg.sv
// Shared types for the 1:4 buffered word dispatcher.
// Lane state encoding doubles as the lane occupancy count.
package dispatch_pkg;

  localparam int WIDTH     = 16;
  localparam int DEPTH     = 2;
  localparam int NUM_LANES = 4;

  typedef logic [1:0]       lane_idx_t;
  typedef logic [WIDTH-1:0] word_t;
  typedef logic [1:0]       cnt_t;

  typedef enum logic [1:0] {
    LS_EMPTY = 2'd0,
    LS_HALF  = 2'd1,
    LS_FULL  = 2'd2
  } lane_state_e;

endpackage

// File: rtl/bus_dispatch4_16_if.sv
// Producer port plus four consumer lanes of the dispatcher.
// master = producer/consumer side, slave = dispatcher side.
interface bus_dispatch4_16_if;
  import dispatch_pkg::*;

  logic      in_valid;
  logic      in_ready;
  lane_idx_t choice;
  word_t     in_data;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  word_t     out_data0;
  word_t     out_data1;
  word_t     out_data2;
  word_t     out_data3;
  logic      busy;

  modport master (
    output in_valid, choice, in_data, out_ready,
    input  in_ready, out_valid, busy,
    input  out_data0, out_data1, out_data2, out_data3
  );

  modport slave (
    input  in_valid, choice, in_data, out_ready,
    output in_ready, out_valid, busy,
    output out_data0, out_data1, out_data2, out_data3
  );

endinterface

// File: rtl/bus_dispatch4_16_lane_fifo2.sv
// Two-entry lane FIFO; state register is the occupancy.
// Head reads 0 while empty so idle lanes present a clean bus.
module lane_fifo2
  import dispatch_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push_i,
  input  logic  pop_i,
  input  word_t data_i,
  output word_t head_o,
  output logic  full_o,
  output logic  empty_o,
  output cnt_t  count_o
);

  lane_state_e state_q, state_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  word_t       mem_q [DEPTH];
  word_t       mem_d [DEPTH];
  logic        push_ok;
  logic        pop_ok;

  always_comb begin
    push_ok  = push_i && (state_q != LS_FULL);
    pop_ok   = pop_i && (state_q != LS_EMPTY);
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q ^ pop_ok;
    wr_ptr_d = wr_ptr_q ^ push_ok;
    mem_d    = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = data_i;
    unique case (state_q)
      LS_EMPTY: begin
        if (push_ok) state_d = LS_HALF;
      end
      LS_HALF: begin
        if (push_ok && !pop_ok)
          state_d = LS_FULL;
        else if (pop_ok && !push_ok)
          state_d = LS_EMPTY;
      end
      LS_FULL: begin
        if (pop_ok) state_d = LS_HALF;
      end
      default: state_d = LS_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LS_EMPTY;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      mem_q    <= mem_d;
    end
  end

  assign empty_o = (state_q == LS_EMPTY);
  assign full_o  = (state_q == LS_FULL);
  assign count_o = cnt_t'(state_q);
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/bus_dispatch4_16.sv
// 1:4 buffered dispatcher: push decode, ready select, busy.
// in_ready never looks at out_ready, so a full lane has no bypass.
module bus_dispatch4_16
  import dispatch_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  bus_dispatch4_16_if.slave   bus
);

  logic [NUM_LANES-1:0] push;
  logic [NUM_LANES-1:0] full;
  logic [NUM_LANES-1:0] empty;
  word_t                head [NUM_LANES];
  cnt_t                 cnt  [NUM_LANES];
  logic                 any_cnt;

  always_comb begin
    push = '0;
    if (bus.in_valid) push[bus.choice] = 1'b1;
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    lane_fifo2 u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push[k]),
      .pop_i   (bus.out_ready[k]),
      .data_i  (bus.in_data),
      .head_o  (head[k]),
      .full_o  (full[k]),
      .empty_o (empty[k]),
      .count_o (cnt[k])
    );
  end

  always_comb begin
    any_cnt = 1'b0;
    for (int k = 0; k < NUM_LANES; k++)
      any_cnt = any_cnt | (cnt[k] != '0);
  end

  assign bus.in_ready  = !full[bus.choice];
  assign bus.out_valid = ~empty;
  assign bus.busy      = any_cnt;
  assign bus.out_data0 = head[0];
  assign bus.out_data1 = head[1];
  assign bus.out_data2 = head[2];
  assign bus.out_data3 = head[3];

endmodule

// File: tb/tb_bus_dispatch4_16.sv
// Scoreboard bench for bus_dispatch4_16: per-lane expected
// queues filled by stimulus, checked by a negedge monitor.
module tb_bus_dispatch4_16;
  import dispatch_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  word_t q [4][$];

  bus_dispatch4_16_if bus ();

  bus_dispatch4_16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic word_t head(input int k);
    case (k)
      0:       return bus.out_data0;
      1:       return bus.out_data1;
      2:       return bus.out_data2;
      default: return bus.out_data3;
    endcase
  endfunction

  always @(negedge clk) begin
    logic any;
    any = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("valid%0d", k),
          32'(bus.out_valid[k]), 32'(q[k].size() != 0));
      if (q[k].size() != 0) begin
        any = 1'b1;
        chk($sformatf("data%0d", k), 32'(head(k)), 32'(q[k][0]));
        if (bus.out_ready[k]) void'(q[k].pop_front());
      end else begin
        chk($sformatf("zero%0d", k), 32'(head(k)), 32'h0);
      end
    end
    chk("busy", 32'(bus.busy), 32'(any));
  end

  task automatic xfer(input logic v, input lane_idx_t ch,
                      input word_t d, input logic [3:0] rdy,
                      input logic exp_rdy, input string nm);
    bus.in_valid  = v;
    bus.choice    = ch;
    bus.in_data   = d;
    bus.out_ready = rdy;
    #2;
    chk(nm, 32'(bus.in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (v && exp_rdy) q[ch].push_back(d);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic rdy_chk(input lane_idx_t ch, input logic exp);
    bus.in_valid = 1'b0;
    bus.choice   = ch;
    #1;
    chk($sformatf("in_ready_c%0d", ch), 32'(bus.in_ready), 32'(exp));
  endtask

  task automatic idle(input logic [3:0] rdy, input int n);
    bus.in_valid  = 1'b0;
    bus.out_ready = rdy;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_cleared(input string nm);
    chk({nm, "_valid"}, 32'(bus.out_valid), 32'h0);
    chk({nm, "_busy"}, 32'(bus.busy), 32'h0);
    chk({nm, "_d0"}, 32'(bus.out_data0), 32'h0);
    chk({nm, "_d1"}, 32'(bus.out_data1), 32'h0);
    chk({nm, "_d2"}, 32'(bus.out_data2), 32'h0);
    chk({nm, "_d3"}, 32'(bus.out_data3), 32'h0);
  endtask

  task automatic drain();
    int n;
    idle(4'b1111, 1);
    n = 0;
    while (bus.busy && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_busy", 32'(bus.busy), 32'h0);
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.choice    = '0;
    bus.in_data   = '0;
    bus.out_ready = '0;
    #1;
    chk_cleared("rst");
    #12;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) rdy_chk(lane_idx_t'(c), 1'b1);

    xfer(1'b1, 2'd2, 16'h1234, 4'b0000, 1'b1, "push_l2");
    idle(4'b0000, 1);

    xfer(1'b1, 2'd1, 16'hAAAA, 4'b0000, 1'b1, "l1_a");
    xfer(1'b1, 2'd1, 16'hBBBB, 4'b0000, 1'b1, "l1_b");
    bus.in_valid = 1'b1;
    bus.choice   = 2'd1;
    bus.in_data  = 16'hCCCC;
    #1;
    chk("l1_full", 32'(bus.in_ready), 32'h0);
    bus.choice = 2'd0;
    #1;
    chk("l0_free", 32'(bus.in_ready), 32'h1);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;

    xfer(1'b1, 2'd1, 16'hCCCC, 4'b0010, 1'b0, "pop_full");
    xfer(1'b1, 2'd1, 16'hCCCC, 4'b0000, 1'b1, "after_pop");
    idle(4'b0000, 1);

    xfer(1'b1, 2'd3, 16'h0001, 4'b0000, 1'b1, "l3_a");
    xfer(1'b1, 2'd3, 16'h0002, 4'b1000, 1'b1, "l3_pp");
    idle(4'b0000, 1);
    rdy_chk(2'd3, 1'b1);
    drain();

    xfer(1'b1, 2'd0, 16'h1111, 4'b0000, 1'b1, "f0a");
    xfer(1'b1, 2'd2, 16'h2222, 4'b0000, 1'b1, "f2a");
    xfer(1'b1, 2'd0, 16'h3333, 4'b0000, 1'b1, "f0b");
    xfer(1'b1, 2'd2, 16'h4444, 4'b0000, 1'b1, "f2b");
    rdy_chk(2'd0, 1'b0);
    rdy_chk(2'd2, 1'b0);
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) q[k].delete();
    #1;
    chk_cleared("mid_rst");
    for (int c = 0; c < 4; c++) rdy_chk(lane_idx_t'(c), 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    xfer(1'b1, 2'd0, 16'h5555, 4'b0000, 1'b1, "post_a");
    xfer(1'b1, 2'd0, 16'h6666, 4'b0000, 1'b1, "post_b");
    idle(4'b0001, 1);
    idle(4'b0000, 1);
    drain();
    idle(4'b0000, 1);

    for (int k = 0; k < 4; k++)
      chk($sformatf("q%0d_left", k), 32'(q[k].size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
